// File: rtl/cond_unit.sv
// cond_unit: condition evaluation and architectural flag register for the ARM
// single-cycle datapath, with an interlock for multi-cycle ALU ops whose flags
// arrive after the issue cycle.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   Cond[3:0]             condition field of the instruction in execute
//   ALUFlags[3:0]         {N,Z,C,V} from the ALU (issue cycle or MultiDone cycle)
//   FlagW[1:0]            flag write mask: [1] -> N,Z  [0] -> C,V
//   PCS, RegW, MemW       unconditioned write requests
//   NoWrite               suppress register write (CMP/CMN/TST)
//   MultiStart            instruction launches a multi-cycle ALU op
//   MultiDone             multi-cycle op's ALUFlags are valid this cycle
//   PCSrc, RegWrite,      conditioned write enables
//   MemWrite
//   CondEx                condition passed (and not stalled)
//   Stall                 hold fetch/decode/execute this cycle
//   Flags[3:0]            current flag register {N,Z,C,V}
module cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       MultiStart,
  input  logic       MultiDone,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic       Stall,
  output logic [3:0] Flags
);

  typedef enum logic {StIdle, StPending} state_e;

  state_e     r_state;
  state_e     w_state_d;
  logic [3:0] r_flags;
  logic [3:0] w_flags_d;
  logic [1:0] r_pend_w;
  logic [1:0] w_pend_w_d;

  logic w_n, w_z, w_c, w_v;
  logic w_cond_pass;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_flags  <= 4'b0000;
      r_pend_w <= 2'b00;
    end else begin
      r_state  <= w_state_d;
      r_flags  <= w_flags_d;
      r_pend_w <= w_pend_w_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d  = r_state;
    w_flags_d  = r_flags;
    w_pend_w_d = r_pend_w;
    unique case (r_state)
      StIdle: begin
        // MultiDone is meaningless here; a simultaneous MultiStart wins.
        if (MultiStart) begin
          if (CondEx && (FlagW != 2'b00)) begin
            w_state_d  = StPending;
            w_pend_w_d = FlagW;
          end
        end else if (CondEx) begin
          if (FlagW[1]) w_flags_d[3:2] = ALUFlags[3:2];
          if (FlagW[0]) w_flags_d[1:0] = ALUFlags[1:0];
        end
      end
      StPending: begin
        // Only the deferred write lands here; any other flag writer is
        // either stalled or has FlagW == 00.
        if (MultiDone) begin
          if (r_pend_w[1]) w_flags_d[3:2] = ALUFlags[3:2];
          if (r_pend_w[0]) w_flags_d[1:0] = ALUFlags[1:0];
          w_pend_w_d = 2'b00;
          w_state_d  = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    w_cond_pass = 1'b0;
    unique case (Cond)
      4'b0000: w_cond_pass = w_z;
      4'b0001: w_cond_pass = ~w_z;
      4'b0010: w_cond_pass = w_c;
      4'b0011: w_cond_pass = ~w_c;
      4'b0100: w_cond_pass = w_n;
      4'b0101: w_cond_pass = ~w_n;
      4'b0110: w_cond_pass = w_v;
      4'b0111: w_cond_pass = ~w_v;
      4'b1000: w_cond_pass = w_c & ~w_z;
      4'b1001: w_cond_pass = ~w_c | w_z;
      4'b1010: w_cond_pass = (w_n == w_v);
      4'b1011: w_cond_pass = (w_n != w_v);
      4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
      4'b1101: w_cond_pass = w_z | (w_n != w_v);
      4'b1110: w_cond_pass = 1'b1;
      4'b1111: w_cond_pass = 1'b0;
      default: w_cond_pass = 1'b0;
    endcase

    // While flags are outstanding, only unconditional non-flag-setting
    // instructions may proceed.
    Stall = (r_state == StPending) && ((Cond != 4'b1110) || (FlagW != 2'b00));

    CondEx   = w_cond_pass & ~Stall;
    PCSrc    = PCS & CondEx;
    RegWrite = RegW & CondEx & ~NoWrite;
    MemWrite = MemW & CondEx;
    Flags    = r_flags;
  end

endmodule
